// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register sitting directly in front of the execute-stage ALU.
// Operand 2 (register vs. immediate) and the destination register (rd vs. rt)
// are resolved here, so the ALU consumes data1_o/data2_o/ALUCtrl_o as-is.
//
// Update priority on each rising edge: rst_i > flush_i > stall_i > load.
//   - flush_i loads a bubble (all outputs zero) and bumps the bubble counter.
//   - stall_i holds every register, including the bubble counter.
//   - A load with valid_i = 0 suppresses RegWrite/MemRead/MemWrite and also
//     counts as a bubble.
// bubble_cnt_o saturates at all-ones and is only cleared by reset.
//
// Optional build macro: ID_EX_WB_BYPASS_EN
//   When defined, a WB-stage write to the register being read in the same
//   cycle (non-zero address) replaces the register-file value for rs and/or
//   rt. When undefined, the wb_* ports are present but ignored.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   stall_i, flush_i, valid_i    pipeline control from hazard unit / ID
//   rs_data_i, rt_data_i, imm_i  operands from ID
//   rs/rt/rd_addr_i              register fields
//   ALUCtrl_i, ALUSrc_i, RegDst_i, RegWrite_i, MemRead_i, MemWrite_i,
//   MemtoReg_i                   decoded control
//   wb_regwrite_i, wb_addr_i, wb_data_i   WB-stage write port (bypass)
//   data1_o, data2_o, ALUCtrl_o  ALU inputs
//   store_data_o                 rt value for stores
//   wr_addr_o, rs_addr_o, rt_addr_o       register addresses
//   RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, valid_o
//   bubble_cnt_o                 saturating count of bubble loads
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          valid_i,
    input  logic [DW-1:0] rs_data_i,
    input  logic [DW-1:0] rt_data_i,
    input  logic [DW-1:0] imm_i,
    input  logic [AW-1:0] rs_addr_i,
    input  logic [AW-1:0] rt_addr_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic [3:0]    ALUCtrl_i,
    input  logic          ALUSrc_i,
    input  logic          RegDst_i,
    input  logic          RegWrite_i,
    input  logic          MemRead_i,
    input  logic          MemWrite_i,
    input  logic          MemtoReg_i,
    input  logic          wb_regwrite_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic [DW-1:0] wb_data_i,
    output logic [DW-1:0] data1_o,
    output logic [DW-1:0] data2_o,
    output logic [3:0]    ALUCtrl_o,
    output logic [DW-1:0] store_data_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [AW-1:0] rs_addr_o,
    output logic [AW-1:0] rt_addr_o,
    output logic          RegWrite_o,
    output logic          MemRead_o,
    output logic          MemWrite_o,
    output logic          MemtoReg_o,
    output logic          valid_o,
    output logic [CW-1:0] bubble_cnt_o
);

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    logic [DW-1:0] data1_q, data1_d;
    logic [DW-1:0] data2_q, data2_d;
    logic [DW-1:0] store_q, store_d;
    logic [3:0]    alu_q, alu_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rs_q, rs_d;
    logic [AW-1:0] rt_q, rt_d;
    logic          regwrite_q, regwrite_d;
    logic          memread_q, memread_d;
    logic          memwrite_q, memwrite_d;
    logic          memtoreg_q, memtoreg_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;

    // Operand source: register file, optionally overridden by a same-cycle
    // WB write. Register 0 is never bypassed since it is hardwired to zero.
    always_comb begin
        rs_val = rs_data_i;
        rt_val = rt_data_i;
`ifdef ID_EX_WB_BYPASS_EN
        if (wb_regwrite_i && (wb_addr_i != '0) && (wb_addr_i == rs_addr_i))
            rs_val = wb_data_i;
        if (wb_regwrite_i && (wb_addr_i != '0) && (wb_addr_i == rt_addr_i))
            rt_val = wb_data_i;
`endif
    end

`ifndef ID_EX_WB_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{wb_regwrite_i, wb_addr_i, wb_data_i};
`endif

    always_comb begin
        data1_d    = data1_q;
        data2_d    = data2_q;
        store_d    = store_q;
        alu_d      = alu_q;
        wr_d       = wr_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        memtoreg_d = memtoreg_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;

        if (flush_i) begin
            // Bubble: flush overrides stall and a valid instruction alike.
            data1_d    = '0;
            data2_d    = '0;
            store_d    = '0;
            alu_d      = 4'b0000;
            wr_d       = '0;
            rs_d       = '0;
            rt_d       = '0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            valid_d    = 1'b0;
            cnt_d      = sat_inc(cnt_q);
        end else if (!stall_i) begin
            data1_d    = rs_val;
            data2_d    = ALUSrc_i ? imm_i : rt_val;
            store_d    = rt_val;
            alu_d      = ALUCtrl_i;
            wr_d       = RegDst_i ? rd_addr_i : rt_addr_i;
            rs_d       = rs_addr_i;
            rt_d       = rt_addr_i;
            // State-changing controls are gated so a non-instruction can
            // never write the register file or touch memory.
            regwrite_d = RegWrite_i & valid_i;
            memread_d  = MemRead_i  & valid_i;
            memwrite_d = MemWrite_i & valid_i;
            memtoreg_d = MemtoReg_i;
            valid_d    = valid_i;
            if (!valid_i)
                cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data1_q    <= '0;
            data2_q    <= '0;
            store_q    <= '0;
            alu_q      <= 4'b0000;
            wr_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            data1_q    <= data1_d;
            data2_q    <= data2_d;
            store_q    <= store_d;
            alu_q      <= alu_d;
            wr_q       <= wr_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign data1_o      = data1_q;
    assign data2_o      = data2_q;
    assign store_data_o = store_q;
    assign ALUCtrl_o    = alu_q;
    assign wr_addr_o    = wr_q;
    assign rs_addr_o    = rs_q;
    assign rt_addr_o    = rt_q;
    assign RegWrite_o   = regwrite_q;
    assign MemRead_o    = memread_q;
    assign MemWrite_o   = memwrite_q;
    assign MemtoReg_o   = memtoreg_q;
    assign valid_o      = valid_q;
    assign bubble_cnt_o = cnt_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the execute-stage ALU.
- Captures decoded operands, the 4-bit ALU control code and MEM/WB control bits from ID, and resolves ALUSrc and RegDst before capture; the ALU then reads data1_o/data2_o/ALUCtrl_o with no further muxing.
- Supports stall (hold), flush (bubble insertion) and a saturating bubble counter for performance debug.

Parameters:
- DW, 32, datapath width of operands and immediate.
- AW, 5, register address width.
- CW, 16, bubble counter width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- stall_i  in  1  hold all registers this cycle.
- flush_i  in  1  load a bubble this cycle.
- valid_i  in  1  ID holds a real instruction.
- rs_data_i  in  DW  register file read port 1.
- rt_data_i  in  DW  register file read port 2.
- imm_i  in  DW  sign-extended immediate.
- rs_addr_i, rt_addr_i, rd_addr_i  in  AW each  register fields.
- ALUCtrl_i  in  4  0010 add, 0110 sub, 0000 and, 0001 or, 0011 mult.
- ALUSrc_i  in  1  1 selects imm_i as operand 2.
- RegDst_i  in  1  1 selects rd, 0 selects rt as write address.
- RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i  in  1 each  downstream control.
- wb_regwrite_i  in  1  WB-stage write enable (bypass feature).
- wb_addr_i  in  AW  WB-stage write address (bypass feature).
- wb_data_i  in  DW  WB-stage write data (bypass feature).
- data1_o, data2_o  out  DW  ALU operands.
- ALUCtrl_o  out  4  ALU operation.
- store_data_o  out  DW  rt value for stores.
- wr_addr_o  out  AW  resolved destination register.
- rs_addr_o, rt_addr_o  out  AW  for EX-stage forwarding.
- RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, valid_o  out  1 each.
- bubble_cnt_o  out  CW  count of bubble loads.

Behaviour:
- Update priority per rising edge: rst_i > flush_i > stall_i > normal load.
- Reset: every output is 0, including ALUCtrl_o = 4'b0000 and bubble_cnt_o = 0.
- Normal load: one-cycle latency.
  - data1_o <= rs_val.
  - data2_o <= ALUSrc_i ? imm_i : rt_val.
  - store_data_o <= rt_val.
  - wr_addr_o <= RegDst_i ? rd_addr_i : rt_addr_i.
  - All control bits and valid_o <= the corresponding inputs.
  - rs_val/rt_val are rs_data_i/rt_data_i unless the bypass feature applies.
- Non-instruction load: if valid_i = 0, RegWrite_o, MemRead_o and MemWrite_o are forced to 0 regardless of their inputs.
- Stall: every register, including bubble_cnt_o, holds its value.
- Flush (including flush with stall, or flush with valid_i = 1):
  - valid_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o <= 0.
  - ALUCtrl_o <= 4'b0000.
  - data1_o, data2_o, store_data_o, wr_addr_o, rs_addr_o, rt_addr_o <= 0.
  - bubble_cnt_o increments.
- Bubble counter:
  - Also increments on a normal load with valid_i = 0.
  - Saturates at all-ones and never wraps; cleared only by rst_i.
- No combinational path from any input to any output.
- Reset asserted mid-stall or mid-flush: reset wins in that cycle; normal loading resumes on the first edge after deassertion.

Optional Feature:
- Macro: ID_EX_WB_BYPASS_EN.
- Defined: on load, if wb_regwrite_i = 1, wb_addr_i != 0 and wb_addr_i == rs_addr_i, then rs_val = wb_data_i. The same rule, compared against rt_addr_i, sets rt_val. The rt bypass feeds both data2_o (when ALUSrc_i = 0) and store_data_o. This covers a register-file write and read in the same cycle.
- Undefined: rs_val = rs_data_i and rt_val = rt_data_i. The wb_* ports remain present but are ignored.

Test Plan:
- Reset: assert rst_i for 2 cycles with arbitrary inputs -> all outputs 0; bubble_cnt_o = 0.
- Normal loads:
  - Load rs=0x00000005, rt=0x00000003, ALUSrc_i=0, ALUCtrl_i=0110, RegDst_i=1, rd=7, valid_i=1, RegWrite_i=1 -> next cycle data1_o=5, data2_o=3, ALUCtrl_o=0110, wr_addr_o=7, RegWrite_o=1, valid_o=1.
  - Load with ALUSrc_i=1, imm_i=0xFFFFFFFC, rt=0x11, RegDst_i=0, rt_addr=9 -> data2_o=0xFFFFFFFC, store_data_o=0x11, wr_addr_o=9.
- Stall then flush:
  - Hold stall_i for 3 cycles while changing inputs -> outputs unchanged.
  - Assert flush_i together with stall_i -> valid_o=0, all control bits 0, operands 0, bubble_cnt_o increments by 1.
- Saturation: with CW overridden to 2, apply 5 flushes -> bubble_cnt_o = 3 and stays 3.
- Bypass, macro defined:
  - wb_regwrite_i=1, wb_addr_i=rs_addr_i=4, wb_data_i=0xAA, rs_data_i=0x55 -> data1_o=0xAA.
  - Same stimulus with wb_addr_i=0 -> data1_o=0x55.
  - Macro undefined, first stimulus -> data1_o=0x55.
